// File: rtl/piso_tx.sv
// Framed parallel-in, serial-out transmitter: start bit, N data bits LSB first,
// stop bit. All state and outputs update on the falling edge of ck.
module piso_tx #(
   parameter int N = 4
) (
   input  logic         ck,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] d,
   output logic         so,
   output logic         ready,
   output logic         done,
   output logic [1:0]   state_dbg
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [N-1:0]    sh, sh_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            so_n, ready_n, done_n;

   // Handshake: a word transfers on a falling edge where load && ready are both
   // high; d is captured on that edge only and load is ignored while ready is low.

   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (load) begin
               sh_n    = d;
               state_n = START;
            end
         end
         START: begin
            cnt_n   = '0;
            state_n = DATA;
         end
         DATA: begin
            sh_n  = sh >> 1;
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
               state_n = STOP;
            end
         end
         STOP: begin
            if (load) begin
               sh_n    = d;
               state_n = START;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered, so they are decoded from the state being entered;
   // sh_n[0] is the data bit that will be on the line for the coming cycle.
   always_comb begin
      so_n    = 1'b1;
      ready_n = 1'b1;
      done_n  = 1'b0;
      unique case (state_n)
         IDLE: begin
            so_n    = 1'b1;
            ready_n = 1'b1;
         end
         START: begin
            so_n    = 1'b0;
            ready_n = 1'b0;
         end
         DATA: begin
            so_n    = sh_n[0];
            ready_n = 1'b0;
         end
         STOP: begin
            so_n    = 1'b1;
            ready_n = 1'b1;
            done_n  = 1'b1;
         end
         default: begin
            so_n    = 1'b1;
            ready_n = 1'b1;
         end
      endcase
   end

   always_ff @(negedge ck) begin
      if (rst) begin
         state <= IDLE;
         sh    <= '0;
         cnt   <= '0;
         so    <= 1'b1;
         ready <= 1'b1;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         sh    <= sh_n;
         cnt   <= cnt_n;
         so    <= so_n;
         ready <= ready_n;
         done  <= done_n;
      end
   end

   assign state_dbg = state;

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out frame transmitter. It is the sending end of the loadable-register datapath: it accepts an N-bit word on a `load` strobe, then shifts it out one bit per clock as a framed serial stream (start bit, N data bits LSB first, stop bit). It sits between a parallel register stage and a single-wire serial link. The receiving deserializer on the far end of the link is a separate block.

## Interface
- `N`, default 4: data word width; legal range 2–16.

- `ck`  input  1  clock; all state updates on the falling edge.
- `rst`  input  1  synchronous, active-high reset, sampled on the falling edge of `ck`.
- `load`  input  1  request to transmit `d`; honoured only when `ready`=1.
- `d`  input  N  parallel word to send.
- `so`  output  1  serial line; idles high.
- `ready`  output  1  block can accept `load` this cycle.
- `done`  output  1  high during the stop-bit cycle of each frame.

## Operation
- All outputs are registered. They change only on the falling edge of `ck`.
- Internal state:
  - FSM with states IDLE, START, DATA, STOP.
  - N-bit shift register `sh`.
  - Bit counter `cnt`, width ceil(log2 N).
- Reset (`rst`=1 at a falling edge) gives: state=IDLE, `so`=1, `ready`=1, `done`=0, `sh`=0, `cnt`=0. `rst` has priority over `load`.
- IDLE: `so`=1, `ready`=1, `done`=0.
  - If `load`=1: `sh`<=`d`, go to START.
- START: `so`=0, `ready`=0. Next state is DATA with `cnt`=0.
- DATA: `so`=`sh[0]`, `ready`=0.
  - Each edge: `sh`<=`sh`>>1 and `cnt`<=`cnt`+1.
  - After the cycle with `cnt`=N-1, go to STOP.
- STOP: `so`=1, `done`=1, `ready`=1.
  - If `load`=1: `sh`<=`d`, go to START (back-to-back frame).
  - Otherwise go to IDLE.
- `load` is ignored in START and DATA. `d` is sampled only on the accepting edge, so later changes to `d` do not affect the frame in flight.
- Frame on `so`: 0, d[0], d[1], …, d[N-1], 1.
- Reset mid-frame aborts the frame. `so` returns to 1 at that edge and no `done` pulse is produced.

## Timing
- Latency: `load` is sampled at falling edge T0. The start bit appears on `so` immediately after T0 and holds until T1. Data bit k is driven from edge T(1+k) to T(2+k). The stop bit is driven from T(N+1) to T(N+2).
- Frame length is N+2 cycles.
  - Back-to-back throughput: one frame every N+2 cycles, with no idle bit between frames.
  - With an IDLE gap: at least N+3 cycles between `load` strobes.
- `ready`:
  - Falls at T0.
  - Rises at T(N+1), the start of the stop cycle.
  - Stays high in IDLE.
- `done`: exactly one cycle high per completed frame, from T(N+1) to T(N+2).
- Simultaneous `rst`=1 and `load`=1: reset wins and the load is lost.

## Test plan
- Reset: hold `rst`=1 for 2 edges with `load`=1 and `d`=4'b1111. Required: `so`=1, `ready`=1, `done`=0 throughout; no frame starts.
- Single frame, N=4: `d`=4'b1011 with a one-cycle `load`. Required: `so` = 0,1,1,0,1,1 over 6 cycles, then idles at 1. `ready` is low for 5 cycles. `done` is high only in cycle 6.
- Busy ignore:
  - Load 4'b0001.
  - During the DATA cycles, pulse `load` with `d`=4'b1110.
  - Required: `so` = 0,1,0,0,0,1, then 1 (idle). No second frame is sent.
- Back-to-back:
  - Load 4'b0011.
  - Assert `load` with `d`=4'b0100 during that frame's stop cycle.
  - Required: `so` = 0,1,1,0,0,1,0,0,0,1,0,1 over 12 cycles.
  - Required: `done` is high in cycles 6 and 12.
- Mid-frame reset:
  - Load 4'b0101.
  - Assert `rst` for one edge at the 2nd data bit.
  - Required: `so`=1 and `ready`=1 from that edge on, and no `done` pulse.
  - Then load 4'b1000. Required: a clean frame 0,0,0,0,1,1.
- N=8 instance: load 8'hA5. Required: `so` = 0,1,0,1,0,0,1,0,1,1 (10 cycles), with `done` high in cycle 10.
